// File: rtl/dice_race_pkg.sv
// Shared definitions for the dice race game: board geometry, player
// encodings, the turn sequencer state type and the index-to-pixel helper.
package dice_race_pkg;

  localparam int NUM_CELLS = 20;
  localparam int START_X   = 20;
  localparam int CELL_W    = 30;
  localparam int FLAG_X    = START_X + NUM_CELLS * CELL_W;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  typedef enum logic [2:0] {
    WAIT_ROLL,
    ADVANCE,
    ISSUE,
    WAIT_DONE,
    NEXT,
    GAME_OVER
  } state_t;

  // Board index to the pixel x of that cell's target position.
  function automatic logic [9:0] idx_to_x(input logic [4:0] idx);
    return 10'(START_X + CELL_W * int'(idx));
  endfunction

endpackage

// File: rtl/dice_turn_manager_if.sv
// Bundle between the turn sequencer and its neighbours: dice input from the
// detection path, turn_done from player_controller, and the target/status
// outputs. The slave side is the turn manager itself.
interface dice_turn_manager_if;

  logic [2:0] dice_value;
  logic       dice_valid;
  logic       turn_done;
  logic [9:0] player1_pos_x;
  logic [9:0] player2_pos_x;
  logic       pos_valid;
  logic       active_player;
  logic [2:0] last_roll;
  logic       busy;
  logic       game_over;
  logic       winner;

  modport master (
    output dice_value, dice_valid, turn_done,
    input  player1_pos_x, player2_pos_x, pos_valid, active_player,
           last_roll, busy, game_over, winner
  );

  modport slave (
    input  dice_value, dice_valid, turn_done,
    output player1_pos_x, player2_pos_x, pos_valid, active_player,
           last_roll, busy, game_over, winner
  );

endinterface

// File: rtl/dice_turn_manager.sv
// Turn-based sequencer for the dice race. Accepts a dice roll, advances the
// active player's board index (clamped at the flag), publishes registered
// pixel targets with a one-cycle pos_valid, then waits for turn_done (or a
// timeout) before handing the turn over or declaring a winner.
// Optional build macro EXTRA_ROLL_ON_SIX_EN: a roll of 6 that does not win
// gives the same player another roll instead of alternating.
module dice_turn_manager
  import dice_race_pkg::*;
#(
  parameter int DONE_TIMEOUT = 25000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                game_start,
  dice_turn_manager_if.slave  bus
);

  localparam int CNT_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  state_t           state;
  state_t           state_next;
  logic [4:0]       idx_p1;
  logic [4:0]       idx_p2;
  logic [4:0]       cur_idx;
  logic [5:0]       sum;
  logic [4:0]       new_idx;
  logic [CNT_W-1:0] timeout_cnt;
  logic             timeout_hit;
  logic             dice_ok;
  logic             won;
  logic             keep_player;

  assign cur_idx     = (bus.active_player == PLAYER2) ? idx_p2 : idx_p1;
  assign sum         = {1'b0, cur_idx} + {3'b000, bus.last_roll};
  assign new_idx     = (sum > 6'(NUM_CELLS)) ? 5'(NUM_CELLS) : sum[4:0];
  assign timeout_hit = (timeout_cnt == CNT_W'(DONE_TIMEOUT - 1));
  assign dice_ok     = bus.dice_valid && (bus.dice_value != 3'd0) && (bus.dice_value != 3'd7);
  assign won         = (cur_idx == 5'(NUM_CELLS));

`ifdef EXTRA_ROLL_ON_SIX_EN
  assign keep_player = (bus.last_roll == 3'd6);
`else
  assign keep_player = 1'b0;
`endif

  assign bus.busy      = (state != WAIT_ROLL) && (state != GAME_OVER);
  assign bus.game_over = (state == GAME_OVER);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_ROLL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection; game_start overrides everything else.
  always_comb begin
    state_next = state;
    if (game_start) begin
      state_next = WAIT_ROLL;
    end else begin
      case (state)
        WAIT_ROLL: if (dice_ok) state_next = ADVANCE;
        ADVANCE:   state_next = ISSUE;
        ISSUE:     state_next = WAIT_DONE;
        WAIT_DONE: if (bus.turn_done || timeout_hit) state_next = NEXT;
        NEXT:      state_next = won ? GAME_OVER : WAIT_ROLL;
        GAME_OVER: state_next = GAME_OVER;
        default:   state_next = WAIT_ROLL;
      endcase
    end
  end

  // Completion timeout: counts only while waiting, so it is clear on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt <= '0;
    end else if (state != WAIT_DONE) begin
      timeout_cnt <= '0;
    end else begin
      timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

  // Game datapath: roll latch, board indices, pixel targets, turn ownership.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_p1            <= '0;
      idx_p2            <= '0;
      bus.player1_pos_x <= 10'(START_X);
      bus.player2_pos_x <= 10'(START_X);
      bus.pos_valid     <= 1'b0;
      bus.active_player <= PLAYER1;
      bus.last_roll     <= 3'd0;
      bus.winner        <= PLAYER1;
    end else begin
      bus.pos_valid <= (state_next == ISSUE);
      if (game_start) begin
        idx_p1            <= '0;
        idx_p2            <= '0;
        bus.player1_pos_x <= 10'(START_X);
        bus.player2_pos_x <= 10'(START_X);
        bus.active_player <= PLAYER1;
        bus.last_roll     <= 3'd0;
        bus.winner        <= PLAYER1;
      end else begin
        case (state)
          WAIT_ROLL: begin
            if (dice_ok) bus.last_roll <= bus.dice_value;
          end
          ADVANCE: begin
            if (bus.active_player == PLAYER2) begin
              idx_p2            <= new_idx;
              bus.player2_pos_x <= idx_to_x(new_idx);
            end else begin
              idx_p1            <= new_idx;
              bus.player1_pos_x <= idx_to_x(new_idx);
            end
          end
          NEXT: begin
            if (won) begin
              bus.winner <= bus.active_player;
            end else if (!keep_player) begin
              bus.active_player <= ~bus.active_player;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dice_turn_manager.sv
// Self-checking bench for dice_turn_manager: directed scenarios followed by
// random play, all compared against a turn-level model of the game rules.
module tb_dice_turn_manager;
  import dice_race_pkg::*;

  localparam int TB_TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic game_start = 1'b0;

  dice_turn_manager_if bus();

  dice_turn_manager #(.DONE_TIMEOUT(TB_TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .game_start (game_start),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Game model: board positions per player, whose turn, last roll, result.
  int m_idx [2];
  int m_active;
  int m_last;
  int m_over;
  int m_winner;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic void modelReset();
    m_idx[0] = 0;
    m_idx[1] = 0;
    m_active = 0;
    m_last   = 0;
    m_over   = 0;
    m_winner = 0;
  endfunction

  function automatic void modelEndTurn();
    int a;
    a = m_active;
    if (m_idx[a] == NUM_CELLS) begin
      m_over   = 1;
      m_winner = a;
    end else begin
`ifdef EXTRA_ROLL_ON_SIX_EN
      if (m_last != 6) m_active = 1 - m_active;
`else
      m_active = 1 - m_active;
`endif
    end
  endfunction

  task automatic checkState(input string tag, input int exp_busy);
    checkOutput({tag, "_p1x"}, bus.player1_pos_x, START_X + CELL_W * m_idx[0]);
    checkOutput({tag, "_p2x"}, bus.player2_pos_x, START_X + CELL_W * m_idx[1]);
    checkOutput({tag, "_active"}, bus.active_player, m_active);
    checkOutput({tag, "_last"}, bus.last_roll, m_last);
    checkOutput({tag, "_over"}, bus.game_over, m_over);
    checkOutput({tag, "_busy"}, bus.busy, exp_busy);
    if (m_over != 0) checkOutput({tag, "_winner"}, bus.winner, m_winner);
  endtask

  // Present one dice pulse; on acceptance, end at the pos_valid cycle.
  task automatic applyStimulus(input int v);
    int a;
    bus.dice_valid = 1'b1;
    bus.dice_value = 3'(v);
    step();
    bus.dice_valid = 1'b0;
    bus.dice_value = 3'($urandom_range(0, 7));
    if (v >= 1 && v <= 6 && m_over == 0) begin
      a = m_active;
      m_last = v;
      m_idx[a] = (m_idx[a] + v > NUM_CELLS) ? NUM_CELLS : m_idx[a] + v;
      checkOutput("advance_pv", bus.pos_valid, 0);
      checkOutput("advance_busy", bus.busy, 1);
      step();
      checkOutput("issue_pv", bus.pos_valid, 1);
      checkState("issue", 1);
    end else begin
      checkOutput("ignored_pv", bus.pos_valid, 0);
      step();
      checkOutput("ignored_pv2", bus.pos_valid, 0);
      checkState("ignored", 0);
    end
  endtask

  // Complete a turn from the pos_valid cycle: 0 turn_done, 1 timeout,
  // 2 turn_done preceded by a stray dice pulse.
  task automatic finishTurn(input int mode);
    int d;
    int prev_active;
    prev_active = m_active;
    if (mode == 1) begin
      for (int i = 1; i <= TB_TIMEOUT + 1; i++) begin
        step();
        if (i == 1) checkOutput("wait_pv_low", bus.pos_valid, 0);
        if (i == TB_TIMEOUT) checkOutput("to_active_held", bus.active_player, prev_active);
      end
      checkOutput("to_not_early", bus.busy, 1);
    end else begin
      d = $urandom_range(2, 8);
      for (int i = 1; i <= d; i++) begin
        step();
        if (i == 1) begin
          checkOutput("wait_pv_low", bus.pos_valid, 0);
          if (mode == 2) begin
            bus.dice_valid = 1'b1;
            bus.dice_value = 3'($urandom_range(1, 6));
          end
        end
        if (i == 2 && mode == 2) begin
          bus.dice_valid = 1'b0;
          checkOutput("stray_last", bus.last_roll, m_last);
          checkOutput("stray_pv", bus.pos_valid, 0);
        end
      end
      bus.turn_done = 1'b1;
      step();
      bus.turn_done = 1'b0;
      checkOutput("next_busy", bus.busy, 1);
    end
    checkOutput("next_pv", bus.pos_valid, 0);
    step();
    modelEndTurn();
    checkState(mode == 1 ? "timeout" : "turn", 0);
  endtask

  task automatic doGameStart();
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    modelReset();
    checkState("gstart", 0);
    checkOutput("gstart_pv", bus.pos_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v;
    int accepted;
    int mode;
    bus.dice_value = 3'd0;
    bus.dice_valid = 1'b0;
    bus.turn_done  = 1'b0;
    modelReset();

    // Reset state.
    repeat (3) step();
    checkState("reset", 0);
    checkOutput("reset_pv", bus.pos_valid, 0);
    rst_n = 1'b1;
    step();

    // First roll of 3 by player 1.
    applyStimulus(3);
    checkOutput("roll3_p1x", bus.player1_pos_x, 110);
    checkOutput("roll3_p2x", bus.player2_pos_x, 20);
    checkOutput("roll3_active", bus.active_player, 0);
    finishTurn(0);

    // Illegal pips are ignored; stray dice during WAIT_DONE is ignored.
    applyStimulus(0);
    applyStimulus(7);
    applyStimulus(2);
    finishTurn(2);

    // Player 1 reaches 18 then rolls 5: clamped at the flag and wins.
    doGameStart();
    for (int r = 0; r < 3; r++) begin
      if (m_over == 0) begin applyStimulus(6); finishTurn(0); end
      if (m_over == 0) begin applyStimulus(1); finishTurn(0); end
    end
    if (m_over == 0) begin applyStimulus(5); finishTurn(0); end
`ifndef EXTRA_ROLL_ON_SIX_EN
    checkOutput("flag_x", bus.player1_pos_x, FLAG_X);
    checkOutput("flag_over", bus.game_over, 1);
    checkOutput("flag_winner", bus.winner, 0);
`endif
    applyStimulus(4);

    // Turn completes by timeout.
    doGameStart();
    applyStimulus(2);
    finishTurn(1);

    // game_start together with turn_done while waiting.
    applyStimulus(5);
    step();
    game_start = 1'b1;
    bus.turn_done = 1'b1;
    step();
    game_start = 1'b0;
    bus.turn_done = 1'b0;
    modelReset();
    checkState("gs_wait", 0);
    checkOutput("gs_wait_pv", bus.pos_valid, 0);
    step();
    checkOutput("gs_wait_pv2", bus.pos_valid, 0);

    // Asynchronous reset in the middle of ADVANCE.
    applyStimulus(4);
    finishTurn(0);
    bus.dice_valid = 1'b1;
    bus.dice_value = 3'd3;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkState("async_rst", 0);
    checkOutput("async_rst_pv", bus.pos_valid, 0);
    bus.dice_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Roll of 6: same player again only with the extra-roll build.
    applyStimulus(6);
    finishTurn(0);
`ifdef EXTRA_ROLL_ON_SIX_EN
    checkOutput("six_active", bus.active_player, 0);
`else
    checkOutput("six_active", bus.active_player, 1);
`endif

    // Random play.
    for (int t = 0; t < 150; t++) begin
      if (m_over != 0) begin
        applyStimulus($urandom_range(0, 7));
        doGameStart();
      end else if ($urandom_range(0, 14) == 0) begin
        doGameStart();
      end else begin
        v = $urandom_range(0, 7);
        accepted = (v >= 1 && v <= 6) ? 1 : 0;
        applyStimulus(v);
        if (accepted != 0) begin
          mode = $urandom_range(0, 9);
          finishTurn(mode == 0 ? 1 : (mode <= 3 ? 2 : 0));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
